// File: rtl/column_streamer_if.sv
// Column streamer bus: raster pixel input and column output to XMoment.
// master drives pixels and observes columns; slave is the streamer itself.
interface column_streamer_if #(
   parameter int LUMA_BITS     = 8,
   parameter int WINDOW_SIZE_Y = 5,
   parameter int IMAGE_WIDTH   = 26
);
   localparam int XW = $clog2(IMAGE_WIDTH);

   logic                                     in_valid;
   logic                                     in_sof;
   logic [LUMA_BITS-1:0]                     in_pixel;
   logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0]  out_column;
   logic                                     out_valid;
   logic                                     out_reset;
   logic [XW-1:0]                            out_x;

   modport master (
      output in_valid, in_sof, in_pixel,
      input  out_column, out_valid, out_reset, out_x
   );

   modport slave (
      input  in_valid, in_sof, in_pixel,
      output out_column, out_valid, out_reset, out_x
   );
endinterface

// File: rtl/column_streamer.sv
// Raster pixels in, vertical WINDOW_SIZE_Y columns out via Y-1 line buffers.
// COLUMN_STREAMER_ROW_RESET_EN: out_reset on every row start, else once per frame.
module column_streamer #(
   parameter int LUMA_BITS     = 8,
   parameter int WINDOW_SIZE_Y = 5,
   parameter int IMAGE_WIDTH   = 26
) (
   input logic               clk,
   input logic               in_reset,
   column_streamer_if.slave  bus
);
   localparam int XW = $clog2(IMAGE_WIDTH);
   localparam int RW = $clog2(WINDOW_SIZE_Y);
   localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] R_FULL = RW'(WINDOW_SIZE_Y - 1);

   logic [LUMA_BITS-1:0] r_linebuf [WINDOW_SIZE_Y-1][IMAGE_WIDTH];
   logic [XW-1:0]        r_x_cnt;
   logic [RW-1:0]        r_rows_seen;

   logic                 w_sof;
   logic [XW-1:0]        w_x;
   logic                 w_wrap;
   logic                 w_primed;
   logic                 w_first;
   logic [WINDOW_SIZE_Y-1:0][LUMA_BITS-1:0] w_col;

   // A start-of-frame pixel restarts the raster at x=0 of row 0
   assign w_sof    = bus.in_valid & bus.in_sof;
   assign w_x      = w_sof ? '0 : r_x_cnt;
   assign w_wrap   = (w_x == X_LAST);
   assign w_primed = !w_sof && (r_rows_seen == R_FULL);

`ifdef COLUMN_STREAMER_ROW_RESET_EN
   assign w_first = (w_x == '0);
`else
   logic r_first_done;

   assign w_first = (w_x == '0) && !r_first_done;

   // Remember that this frame already produced its restart marker
   always_ff @(posedge clk or posedge in_reset) begin
      if (in_reset) begin
         r_first_done <= 1'b0;
      end else if (w_sof) begin
         r_first_done <= 1'b0;
      end else if (bus.in_valid && w_primed && w_first) begin
         r_first_done <= 1'b1;
      end
   end
`endif

   // Assemble the column: buffered rows on top, the live pixel at the bottom
   always_comb begin
      w_col = '0;
      for (int k = 0; k < WINDOW_SIZE_Y - 1; k++) begin
         w_col[k] = r_linebuf[k][w_x];
      end
      w_col[WINDOW_SIZE_Y-1] = bus.in_pixel;
   end

   // Line buffers shift up one row at the accepted column; RAM needs no reset
   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         for (int k = 0; k < WINDOW_SIZE_Y - 2; k++) begin
            r_linebuf[k][w_x] <= r_linebuf[k+1][w_x];
         end
         r_linebuf[WINDOW_SIZE_Y-2][w_x] <= bus.in_pixel;
      end
   end

   // Raster position and buffered-row count; rows saturate once primed
   always_ff @(posedge clk or posedge in_reset) begin
      if (in_reset) begin
         r_x_cnt     <= '0;
         r_rows_seen <= '0;
      end else if (bus.in_valid) begin
         r_x_cnt <= w_wrap ? '0 : w_x + XW'(1);
         if (w_sof) begin
            r_rows_seen <= '0;
         end else if (w_wrap && (r_rows_seen != R_FULL)) begin
            r_rows_seen <= r_rows_seen + RW'(1);
         end
      end
   end

   // Registered column output; data holds across stalls
   always_ff @(posedge clk or posedge in_reset) begin
      if (in_reset) begin
         bus.out_valid  <= 1'b0;
         bus.out_reset  <= 1'b0;
         bus.out_column <= '0;
         bus.out_x      <= '0;
      end else begin
         bus.out_valid <= bus.in_valid & w_primed;
         bus.out_reset <= bus.in_valid & w_primed & w_first;
         if (bus.in_valid) begin
            bus.out_column <= w_col;
            bus.out_x      <= w_x;
         end
      end
   end
endmodule

// File: tb/tb_column_streamer.sv
// Bench for column_streamer: spec vectors, stall/sof/reset sequences,
// then random traffic against a frame-history reference model.
module tb_column_streamer;
   localparam int LB = 8;
   localparam int WY = 5;
   localparam int IW = 26;
   localparam int XW = $clog2(IW);
   localparam int CW = WY * LB;
`ifdef COLUMN_STREAMER_ROW_RESET_EN
   localparam bit ROWRST = 1'b1;
`else
   localparam bit ROWRST = 1'b0;
`endif

   logic clk = 1'b0;
   logic in_reset;
   always #5 clk = ~clk;

   column_streamer_if #(.LUMA_BITS(LB), .WINDOW_SIZE_Y(WY), .IMAGE_WIDTH(IW)) bus();

   column_streamer #(
      .LUMA_BITS(LB), .WINDOW_SIZE_Y(WY), .IMAGE_WIDTH(IW)
   ) dut (
      .clk(clk),
      .in_reset(in_reset),
      .bus(bus.slave)
   );

   logic [CW-1:0] w_out_col;
   assign w_out_col = bus.out_column;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] mkcol(logic [7:0] a0, logic [7:0] a1,
                                           logic [7:0] a2, logic [7:0] a3,
                                           logic [7:0] a4);
      return {a4, a3, a2, a1, a0};
   endfunction

   function automatic logic [7:0] pix(int r, int c);
      return 8'(((r << 5) | c) & 8'hFF);
   endfunction

   // Reference model: every pixel of the current frame indexed by raster order
   int            m_n;
   logic [7:0]    m_hist [int];
   logic          m_v;
   logic          m_r;
   logic [XW-1:0] m_x;
   logic [CW-1:0] m_col;

   task automatic model_clear();
      m_n = 0;
      m_hist.delete();
      m_v = 1'b0;
      m_r = 1'b0;
   endtask

   task automatic model_accept(bit sof, logic [7:0] p);
      int x, row;
      if (sof) begin
         m_n = 0;
         m_hist.delete();
      end
      x   = m_n % IW;
      row = m_n / IW;
      m_hist[m_n] = p;
      m_v = (row >= WY - 1);
      m_r = m_v && (x == 0) && (ROWRST || row == WY - 1);
      if (m_v) begin
         m_x = XW'(x);
         for (int k = 0; k < WY; k++) begin
            m_col[k*LB +: LB] = m_hist[(row - WY + 1 + k) * IW + x];
         end
      end
      m_n++;
   endtask

   task automatic step(bit v, bit sof, logic [7:0] p);
      bus.in_valid = v;
      bus.in_sof   = sof;
      bus.in_pixel = p;
      if (v) model_accept(sof, p);
      else begin
         m_v = 1'b0;
         m_r = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", 64'(bus.out_valid), 64'(m_v));
      chk("out_reset", 64'(bus.out_reset), 64'(m_r));
      if (m_v) begin
         chk("out_x", 64'(bus.out_x), 64'(m_x));
         chk("out_column", 64'(w_out_col), 64'(m_col));
      end
   endtask

   typedef struct {
      int            row;
      int            col;
      bit            v;
      bit            r;
      int            x;
      logic [CW-1:0] c;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{0, 0, 1'b0, 1'b0, 0, '0};
      tbl[1] = '{3, 25, 1'b0, 1'b0, 0, '0};
      tbl[2] = '{4, 0, 1'b1, 1'b1, 0, mkcol(8'h00, 8'h20, 8'h40, 8'h60, 8'h80)};
      tbl[3] = '{4, 7, 1'b1, 1'b0, 7, mkcol(8'h07, 8'h27, 8'h47, 8'h67, 8'h87)};
      tbl[4] = '{5, 25, 1'b1, 1'b0, 25, mkcol(8'h39, 8'h59, 8'h79, 8'h99, 8'hB9)};
      tbl[5] = '{6, 0, 1'b1, ROWRST, 0, mkcol(8'h40, 8'h60, 8'h80, 8'hA0, 8'hC0)};

      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
      bus.in_pixel = '0;
      in_reset     = 1'b1;
      model_clear();
      #2;
      chk("rst_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_reset", 64'(bus.out_reset), 64'(0));
      chk("rst_column", 64'(w_out_col), 64'(0));
      chk("rst_x", 64'(bus.out_x), 64'(0));
      @(posedge clk);
      @(posedge clk);
      #1;
      in_reset = 1'b0;

      // Known frame with table checkpoints and a stall in row 4
      for (int r = 0; r <= 6; r++) begin
         for (int c = 0; c < IW; c++) begin
            if (r == 6 && c >= 10) continue;
            if (r == 4 && c == 7) begin
               for (int s = 0; s < 3; s++) begin
                  step(1'b0, 1'b0, 8'hEE);
                  chk("stall_valid", 64'(bus.out_valid), 64'(0));
                  chk("stall_hold_x", 64'(bus.out_x), 64'(6));
                  chk("stall_hold_col", 64'(w_out_col),
                      64'(mkcol(8'h06, 8'h26, 8'h46, 8'h66, 8'h86)));
               end
            end
            step(1'b1, 1'b0, pix(r, c));
            for (int i = 0; i < 6; i++) begin
               if (tbl[i].row == r && tbl[i].col == c) begin
                  chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[i].v));
                  chk("tbl_reset", 64'(bus.out_reset), 64'(tbl[i].r));
                  if (tbl[i].v) begin
                     chk("tbl_x", 64'(bus.out_x), 64'(tbl[i].x));
                     chk("tbl_column", 64'(w_out_col), 64'(tbl[i].c));
                  end
               end
            end
         end
      end

      // Mid-frame restart at row 6 x=10: four fresh rows before any column
      step(1'b1, 1'b1, 8'h11);
      chk("sof_valid", 64'(bus.out_valid), 64'(0));
      for (int i = 0; i < 4 * IW - 1; i++) begin
         step(1'b1, 1'b0, 8'($urandom));
      end
      step(1'b1, 1'b0, 8'h5A);
      chk("sof_first_valid", 64'(bus.out_valid), 64'(1));
      chk("sof_first_reset", 64'(bus.out_reset), 64'(1));
      chk("sof_first_x", 64'(bus.out_x), 64'(0));
      chk("sof_first_top", 64'(bus.out_column[0]), 64'(8'h11));

      // Advance to mid row 5, then reset asynchronously between edges
      for (int i = 0; i < IW + 4; i++) begin
         step(1'b1, 1'b0, 8'($urandom));
      end
      #3;
      in_reset = 1'b1;
      #1;
      chk("arst_valid", 64'(bus.out_valid), 64'(0));
      chk("arst_reset", 64'(bus.out_reset), 64'(0));
      chk("arst_column", 64'(w_out_col), 64'(0));
      chk("arst_x", 64'(bus.out_x), 64'(0));
      bus.in_valid = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      in_reset = 1'b0;

      // Fresh frame after reset behaves like the first one
      for (int r = 0; r <= 4; r++) begin
         for (int c = 0; c < IW; c++) begin
            if (r == 4 && c > 0) continue;
            step(1'b1, 1'b0, pix(r, c));
         end
      end
      chk("fresh_reset", 64'(bus.out_reset), 64'(1));
      chk("fresh_column", 64'(w_out_col),
          64'(mkcol(8'h00, 8'h20, 8'h40, 8'h60, 8'h80)));

      // Random traffic with bubbles and occasional frame restarts
      for (int i = 0; i < 3000; i++) begin
         bit v, s;
         v = ($urandom % 4) != 0;
         s = v && (($urandom % 600) == 0);
         step(v, s, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
